// File: rtl/shared_mem_arbiter.sv
// Single-port word memory shared by an instruction-fetch client and a data client,
// with wait-state insertion and an optional tohost monitor enabled by MEM_TOHOST_EN.
module shared_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 13,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] imem_addr_i,
    input  logic        imem_read_n_i,
    output logic [31:0] imem_data_o,
    output logic        imem_ready_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [3:0]  dmem_byte_en_i,
    input  logic        dmem_read_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_ready_o,
    output logic        done_o,
    output logic        pass_o,
    output logic [30:0] fail_code_o
);

    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [3:0]        wait_cnt_r;
    logic              grant_dmem_r;
    logic              grant_dmem_next_s;
    logic              imem_req_s;
    logic              dmem_req_s;
    logic              access_s;
    logic              mem_wr_s;
    logic [IDX_W-1:0]  imem_idx_s;
    logic [IDX_W-1:0]  dmem_idx_s;
    logic [31:0]       mem_r [0:DEPTH-1];
    logic              unused_addr_bits_s;

    assign imem_req_s = ~imem_read_n_i;
    assign dmem_req_s = dmem_read_i | (|dmem_byte_en_i);
    assign imem_idx_s = imem_addr_i[ADDR_WIDTH-1:2];
    assign dmem_idx_s = dmem_addr_i[ADDR_WIDTH-1:2];
    assign access_s   = (state_r == ST_ACCESS);
    // A reset edge coinciding with ACCESS must not commit the store.
    assign mem_wr_s   = access_s & grant_dmem_r & reset_n;

    // Sub-word and high address bits are deliberately ignored by the decoder.
    assign unused_addr_bits_s = ^{imem_addr_i, dmem_addr_i};

    // State register; the grant register doubles as the last-grant history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            grant_dmem_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            grant_dmem_r <= grant_dmem_next_s;
        end
    end

    // Next-state and arbitration: DMEM by default, IMEM after a DMEM grant.
    always_comb begin
        next_state_s      = state_r;
        grant_dmem_next_s = grant_dmem_r;
        case (state_r)
            ST_IDLE: begin
                if (imem_req_s || dmem_req_s) begin
                    if (dmem_req_s && !(imem_req_s && grant_dmem_r)) begin
                        grant_dmem_next_s = 1'b1;
                    end else begin
                        grant_dmem_next_s = 1'b0;
                    end
                    if (WAIT_STATES == 0) begin
                        next_state_s = ST_ACCESS;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r <= 4'd1) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ACCESS: next_state_s = ST_RESP;
            ST_RESP:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Wait-state counter, loaded when a grant heads into WAIT.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == ST_IDLE && next_state_s == ST_WAIT) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if (state_r == ST_WAIT && wait_cnt_r != 4'd0) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Array write port with per-lane enables; contents are never reset.
    always_ff @(posedge clk) begin
        if (mem_wr_s) begin
            for (int n = 0; n < 4; n++) begin
                if (dmem_byte_en_i[n]) begin
                    mem_r[dmem_idx_s][8*n +: 8] <= dmem_wdata_i[8*n +: 8];
                end
            end
        end
    end

    // Registered read data and ready pulses; reads see pre-write contents.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            imem_data_o  <= 32'd0;
            dmem_rdata_o <= 32'd0;
            imem_ready_o <= 1'b0;
            dmem_ready_o <= 1'b0;
        end else begin
            imem_ready_o <= access_s & ~grant_dmem_r;
            dmem_ready_o <= access_s & grant_dmem_r;
            if (access_s && !grant_dmem_r) begin
                imem_data_o <= mem_r[imem_idx_s];
            end
            if (access_s && grant_dmem_r && dmem_read_i) begin
                dmem_rdata_o <= mem_r[dmem_idx_s];
            end
        end
    end

`ifdef MEM_TOHOST_EN
    logic        done_r;
    logic        pass_r;
    logic [30:0] fail_code_r;
    logic        tohost_hit_s;

    assign tohost_hit_s = access_s & grant_dmem_r &
                          (dmem_byte_en_i == 4'b1111) & (dmem_addr_i == TOHOST_ADDR);

    // Tohost monitor: only the first full-word store is recorded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_code_r <= 31'd0;
        end else if (tohost_hit_s && !done_r) begin
            done_r      <= 1'b1;
            pass_r      <= (dmem_wdata_i == 32'd1);
            fail_code_r <= dmem_wdata_i[31:1];
        end
    end

    assign done_o      = done_r;
    assign pass_o      = pass_r;
    assign fail_code_o = fail_code_r;
`else
    logic unused_tohost_s;

    assign unused_tohost_s = ^TOHOST_ADDR;
    assign done_o          = 1'b0;
    assign pass_o          = 1'b0;
    assign fail_code_o     = 31'd0;
`endif

endmodule
